// File: rtl/if_pkg.sv
// Shared types for the prefetching instruction fetch stage:
// default width, fetch FIFO entry, drain FSM states, PC step.
package if_pkg;

   localparam int DEF_XLEN = 32;
   localparam int PC_STEP  = 4;

   typedef enum logic {
      RUN,
      DRAIN
   } fetch_state_t;

   typedef struct packed {
      logic [DEF_XLEN-1:0] pc;
      logic [DEF_XLEN-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/if_fetch_fifo.sv
// Synchronous prefetch FIFO; flush beats push, push+pop legal when full.
// Ports: clk, rst, push/din, pop/dout, flush, count, full, empty.
module if_fetch_fifo
   import if_pkg::*;
#(
   parameter int  DEPTH = 4,
   parameter type T     = fetch_entry_t,
   parameter int  CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          pop,
   input  logic          flush,
   input  T              din,
   output T              dout,
   output logic [CW-1:0] count,
   output logic          full,
   output logic          empty
);

   localparam int PW = $clog2(DEPTH);

   T             mem [DEPTH];
   logic [PW-1:0] wp;
   logic [PW-1:0] rp;

   always_ff @(posedge clk) begin
      if (push && !flush) begin
         mem[wp] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wp    <= '0;
         rp    <= '0;
         count <= '0;
      end else begin
         if (push) begin
            wp <= wp + PW'(1);
         end
         if (pop) begin
            rp <= rp + PW'(1);
         end
         if (push && !pop) begin
            count <= count + CW'(1);
         end else if (!push && pop) begin
            count <= count - CW'(1);
         end
      end
   end

   assign dout  = mem[rp];
   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);

endmodule

// File: rtl/if_prefetch_stage.sv
// Prefetching IF stage: pipelined imem requests, in-order responses, FIFO to ID.
// Ports: clk/rst, freeze, branch_taken/branch_addr, mem_req/addr/gnt/rvalid/rdata,
// if_valid/if_pc/if_pc_plus4/if_instr; IF_PREFETCH_PERF_EN adds perf_* counters.
module if_prefetch_stage
   import if_pkg::*;
#(
   parameter int              XLEN            = DEF_XLEN,
   parameter int              FIFO_DEPTH      = 4,
   parameter int              MAX_OUTSTANDING = 2,
   parameter logic [XLEN-1:0] RESET_PC        = '0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            freeze,
   input  logic            branch_taken,
   input  logic [XLEN-1:0] branch_addr,
   output logic            mem_req,
   output logic [XLEN-1:0] mem_addr,
   input  logic            mem_gnt,
   input  logic            mem_rvalid,
   input  logic [XLEN-1:0] mem_rdata,
   output logic            if_valid,
   output logic [XLEN-1:0] if_pc,
   output logic [XLEN-1:0] if_pc_plus4,
   output logic [XLEN-1:0] if_instr
`ifdef IF_PREFETCH_PERF_EN
   ,
   output logic [31:0]     perf_fetched,
   output logic [31:0]     perf_squashed,
   output logic [31:0]     perf_starve
`endif
);

   localparam int OW = $clog2(MAX_OUTSTANDING + 1);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } entry_t;

   logic [XLEN-1:0] fetch_pc, fetch_pc_d;
   logic [XLEN-1:0] rsp_pc, rsp_pc_d;
   logic [XLEN-1:0] tgt;
   logic [OW-1:0]   outst, outst_d;
   logic [OW-1:0]   drop_cnt, drop_d;
   fetch_state_t    state, state_d;

   logic          rsp, grant, drop, push, pop;
   logic          full, empty;
   logic [CW-1:0] count;
   entry_t        din, head;
   logic          unused_baddr_lo;

   assign unused_baddr_lo = ^branch_addr[1:0];
   assign tgt = {branch_addr[XLEN-1:2], 2'b00};

   // Credit: in-flight plus buffered never exceeds FIFO capacity.
   assign mem_req = !rst && !branch_taken
                 && int'(outst) < MAX_OUTSTANDING
                 && int'(outst) + int'(count) < FIFO_DEPTH;
   assign mem_addr = rst ? '0 : fetch_pc;
   assign grant    = mem_req && mem_gnt;

   assign rsp  = mem_rvalid && !rst;
   // A response landing in the branch cycle belongs to the old stream.
   assign drop = rsp && (drop_cnt != '0 || branch_taken);
   assign push = rsp && drop_cnt == '0 && !branch_taken;
   assign din  = '{pc: rsp_pc, instr: mem_rdata};

   assign if_valid    = !rst && !empty;
   assign pop         = if_valid && !freeze && !branch_taken;
   assign if_pc       = if_valid ? head.pc : '0;
   assign if_instr    = if_valid ? head.instr : '0;
   assign if_pc_plus4 = if_valid ? head.pc + STEP : '0;

   if_fetch_fifo #(
      .DEPTH (FIFO_DEPTH),
      .T     (entry_t),
      .CW    (CW)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .flush (branch_taken),
      .din   (din),
      .dout  (head),
      .count (count),
      .full  (full),
      .empty (empty)
   );

   always_comb begin
      fetch_pc_d = fetch_pc;
      rsp_pc_d   = rsp_pc;
      drop_d     = drop_cnt;
      state_d    = state;
      outst_d    = outst + OW'(grant) - OW'(rsp);
      if (grant) begin
         fetch_pc_d = fetch_pc + STEP;
      end
      if (push) begin
         rsp_pc_d = rsp_pc + STEP;
      end
      if (branch_taken) begin
         fetch_pc_d = tgt;
         rsp_pc_d   = tgt;
         drop_d     = outst - OW'(rsp);
      end else if (drop) begin
         drop_d = drop_cnt - OW'(1);
      end
      unique case (state)
         RUN:     if (drop_d != '0) state_d = DRAIN;
         DRAIN:   if (drop_d == '0) state_d = RUN;
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc <= RESET_PC;
         rsp_pc   <= RESET_PC;
         outst    <= '0;
         drop_cnt <= '0;
         state    <= RUN;
      end else begin
         fetch_pc <= fetch_pc_d;
         rsp_pc   <= rsp_pc_d;
         outst    <= outst_d;
         drop_cnt <= drop_d;
         state    <= state_d;
      end
   end

   no_push_when_full: assert property (
      @(posedge clk) disable iff (rst) !(push && full && !pop)
   );

`ifdef IF_PREFETCH_PERF_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_fetched  <= '0;
         perf_squashed <= '0;
         perf_starve   <= '0;
      end else begin
         perf_fetched  <= perf_fetched + 32'(push);
         perf_squashed <= perf_squashed + 32'(drop)
                        + (branch_taken ? 32'(count) : 32'd0);
         perf_starve   <= perf_starve + 32'(!if_valid && !freeze);
      end
   end
`endif

endmodule

// File: doc/if_prefetch_stage.md
Name: if_prefetch_stage

Overview:
- Parametrised successor to the single-PC fetch stage. Decouples instruction fetch from the ID stage through a prefetch FIFO and a pipelined instruction-memory request/response interface with several requests in flight.
- Sits between the instruction memory and the IF/ID register.
- Supports ID stall (freeze) and branch redirect, including flushing the FIFO and squashing responses already in flight.

Parameters:
- XLEN, 32, width of PC, address and instruction.
- FIFO_DEPTH, 4, prefetch FIFO entries; power of two, ≥2.
- MAX_OUTSTANDING, 2, maximum granted-but-unanswered memory requests; 1..FIFO_DEPTH.
- RESET_PC, 0, fetch address after reset.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- freeze  in  1  ID stall; no pop while high.
- branch_taken  in  1  redirect request from EXE.
- branch_addr  in  XLEN  redirect target.
- mem_req  out  1  fetch request valid.
- mem_addr  out  XLEN  fetch address, word aligned.
- mem_gnt  in  1  request accepted this cycle.
- mem_rvalid  in  1  response valid; responses return in request order.
- mem_rdata  in  XLEN  response instruction.
- if_valid  out  1  if_pc/if_instr hold a valid instruction.
- if_pc  out  XLEN  address of the presented instruction.
- if_pc_plus4  out  XLEN  if_pc + 4.
- if_instr  out  XLEN  presented instruction.

Behaviour:
- Reset (rst high at an edge):
  - fetch_pc = rsp_pc = RESET_PC; FIFO empty; outstanding = 0; drop_cnt = 0; state RUN.
  - All outputs 0 while reset is asserted.
  - mem_rvalid is ignored during reset. Memory is reset by the same rst, so it drops all in-flight requests.
- Issue:
  - mem_req = !rst && !branch_taken && outstanding < MAX_OUTSTANDING && (outstanding + fifo_count) < FIFO_DEPTH.
  - mem_addr = fetch_pc.
  - On mem_req && mem_gnt: fetch_pc += 4 (mod 2^XLEN wrap), outstanding++.
- Response:
  - mem_rvalid decrements outstanding.
  - If drop_cnt > 0: discard the response and decrement drop_cnt.
  - Otherwise: push {rsp_pc, mem_rdata} and increment rsp_pc by 4.
  - Credit rule guarantees no push into a full FIFO; an assertion flags any violation.
- Output:
  - if_valid = FIFO non-empty; head entry drives if_pc/if_instr.
  - Pop when if_valid && !freeze.
  - Push and pop in the same cycle are allowed at any occupancy, including full.
  - No bypass: response at cycle N gives if_valid at N+1 at the earliest.
- Branch (branch_taken high at edge N), highest priority:
  - Overrides freeze, push, pop and grant.
  - FIFO cleared.
  - fetch_pc = rsp_pc = {branch_addr[XLEN-1:2], 2'b00}.
  - drop_cnt = outstanding − (mem_rvalid at N ? 1 : 0); a response arriving at cycle N is discarded.
  - if_valid = 0 at N+1.
  - mem_req with the target at N+1 at the earliest.
  - A second branch during DRAIN recomputes drop_cnt by the same rule.
- FSM:
  - RUN → DRAIN when a branch leaves drop_cnt > 0.
  - DRAIN → RUN when drop_cnt reaches 0 (the last dropped response).
  - Issue is permitted in DRAIN; new responses follow the dropped ones by the ordering rule.
- Counters: outstanding and drop_cnt are clog2(MAX_OUTSTANDING+1) bits; fifo_count is clog2(FIFO_DEPTH+1) bits.
- Throughput: with zero-wait memory (gnt=1, rvalid the cycle after) and no freeze, one instruction per cycle steady state.
- Reset-to-first-instruction latency: req at cycle 0, rvalid at 1, if_valid at 2.

Optional Feature:
- Macro: IF_PREFETCH_PERF_EN.
- Defined: adds outputs perf_fetched (32b, count of non-dropped responses), perf_squashed (32b, count of dropped responses plus FIFO entries flushed by branches) and perf_starve (32b, cycles with !if_valid && !freeze). All reset to 0 and wrap on overflow.
- Undefined: these ports and their registers do not exist; all other behaviour is identical.

Decomposition:
- Package if_pkg: XLEN default, the fetch_entry_t struct {pc, instr}, the state enum {RUN, DRAIN}, PC_STEP = 4.
- Sub-module if_fetch_fifo: parametrised synchronous FIFO of fetch_entry_t with push, pop, flush, count, full and empty; flush has priority over push.

Test Plan:
- Reset, zero-wait memory, freeze=0 → mem_addr 0,4,8,...; if_valid from cycle 2; if_pc 0,4,8 with matching if_instr, one per cycle.
- freeze held high 10 cycles with FIFO_DEPTH=4 → FIFO fills to 4, mem_req drops to 0, if_pc frozen. Release → 4 buffered PCs, then new fetches, none lost or duplicated.
- Memory latency 3, MAX_OUTSTANDING=2, branch to 0x100 with 2 outstanding → 2 responses dropped, state DRAIN then RUN, first if_pc=0x100 with correct instruction.
- branch_taken and freeze high together with FIFO full → FIFO empty at N+1, if_valid=0, mem_addr=0x200 for branch_addr=0x203.
- Back-to-back branches (0x40 then 0x80) while responses are in flight → only the 0x80 stream appears; drop_cnt reaches 0 exactly when the last stale rvalid arrives.
- rst asserted mid-stream with 2 outstanding → all outputs 0; after release fetch restarts at RESET_PC and no stale instruction appears.
